// File: rtl/lcd_vram_arbiter_if.sv
// lcd_vram_arbiter_if
//   Bundles the scanout read path, the draw write path and the VRAM macro port
//   of the LCD VRAM arbiter.
//   master : the system side (lcd timing block, draw engine, VRAM macro read data).
//   slave  : the arbiter itself.
//   Signals:
//     disp_req/disp_addr         scanout read request and address
//     disp_rdata/disp_rvalid     scanout read return
//     wr_valid/wr_ready          draw write handshake
//     wr_addr/wr_data            draw write address and pixel
//     vram_en/vram_we            VRAM strobe and write enable
//     vram_addr/vram_wdata       VRAM address and write data
//     vram_rdata                 VRAM read data, one cycle after a read strobe
//     wr_level                   write FIFO occupancy
interface lcd_vram_arbiter_if #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_rvalid;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              vram_en;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_wdata;
  logic [DATA_W-1:0] vram_rdata;
  logic [LVL_W-1:0]  wr_level;

  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data, vram_rdata,
    input  disp_rdata, disp_rvalid, wr_ready, vram_en, vram_we, vram_addr,
           vram_wdata, wr_level
  );

  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, vram_rdata,
    output disp_rdata, disp_rvalid, wr_ready, vram_en, vram_we, vram_addr,
           vram_wdata, wr_level
  );
endinterface

// File: rtl/lcd_vram_arbiter.sv
// lcd_vram_arbiter
//   Shares one single-port VRAM between the LCD scanout (reads, strict
//   priority, never stalled) and the draw engine (writes, buffered in a small
//   FIFO and drained into any cycle scanout leaves idle). Single clock domain.
//   Ports:
//     PixelClk  pixel clock
//     nRST      synchronous active-low reset
//     bus       lcd_vram_arbiter_if slave modport (scanout, draw and VRAM sides)
//   Read latency: disp_req at t -> VRAM strobe at t+1 -> disp_rvalid at t+2.
//   Write latency: accept at t -> earliest VRAM write strobe at t+2 (no bypass).
module lcd_vram_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic                PixelClk,
  input logic                nRST,
  lcd_vram_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  // Operation currently presented on the VRAM port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } op_e;

  op_e               state_r;
  op_e               next_state_s;

  logic [ADDR_W-1:0] fifo_addr_r [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic [LVL_W-1:0]  level_nxt_s;
  logic              wr_ready_r;
  logic              push_s;
  logic              pop_s;
  logic              en_s;
  logic              we_s;

  logic              vram_en_r;
  logic              vram_we_r;
  logic [ADDR_W-1:0] vram_addr_r;
  logic [DATA_W-1:0] vram_wdata_r;
  logic              rd_pend_r;

  // wr_ready_r is registered, so accepting never depends combinationally on wr_valid.
  assign push_s = bus.wr_valid & wr_ready_r;

  // Port owner state register.
  always_ff @(posedge PixelClk) begin
    if (!nRST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next VRAM operation: scanout read always wins, then the FIFO head, else idle.
  always_comb begin
    next_state_s = ST_IDLE;
    if (bus.disp_req) begin
      next_state_s = ST_READ;
    end else if (level_r != {LVL_W{1'b0}}) begin
      next_state_s = ST_WRITE;
    end else begin
      next_state_s = ST_IDLE;
    end
  end

  // Strobe/pop decode for the operation being registered.
  always_comb begin
    en_s  = 1'b0;
    we_s  = 1'b0;
    pop_s = 1'b0;
    case (next_state_s)
      ST_READ: begin
        en_s = 1'b1;
      end
      ST_WRITE: begin
        en_s  = 1'b1;
        we_s  = 1'b1;
        pop_s = 1'b1;
      end
      ST_IDLE: begin
        en_s = 1'b0;
      end
      default: begin
        en_s = 1'b0;
      end
    endcase
  end

  // Occupancy update; push and pop together leave the level unchanged.
  always_comb begin
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_W'(1);
      2'b01:   level_nxt_s = level_r - LVL_W'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // FIFO pointers, level and registered ready; pointers wrap as FIFO_DEPTH is a power of 2.
  always_ff @(posedge PixelClk) begin
    if (!nRST) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      level_r    <= {LVL_W{1'b0}};
      wr_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      level_r    <= level_nxt_s;
      wr_ready_r <= (level_nxt_s < LVL_FULL);
    end
  end

  // FIFO storage; contents need no reset because the pointers and level are cleared.
  always_ff @(posedge PixelClk) begin
    if (push_s) begin
      fifo_addr_r[wr_ptr_r] <= bus.wr_addr;
      fifo_data_r[wr_ptr_r] <= bus.wr_data;
    end
  end

  // Registered VRAM port; address and write data hold while idle.
  always_ff @(posedge PixelClk) begin
    if (!nRST) begin
      vram_en_r    <= 1'b0;
      vram_we_r    <= 1'b0;
      vram_addr_r  <= {ADDR_W{1'b0}};
      vram_wdata_r <= {DATA_W{1'b0}};
    end else begin
      vram_en_r <= en_s;
      vram_we_r <= we_s;
      case (next_state_s)
        ST_READ: begin
          vram_addr_r <= bus.disp_addr;
        end
        ST_WRITE: begin
          vram_addr_r  <= fifo_addr_r[rd_ptr_r];
          vram_wdata_r <= fifo_data_r[rd_ptr_r];
        end
        default: begin
          vram_addr_r <= vram_addr_r;
        end
      endcase
    end
  end

  // A read on the port this cycle means VRAM data returns next cycle.
  always_ff @(posedge PixelClk) begin
    if (!nRST) begin
      rd_pend_r <= 1'b0;
    end else begin
      rd_pend_r <= (state_r == ST_READ);
    end
  end

  assign bus.vram_en     = vram_en_r;
  assign bus.vram_we     = vram_we_r;
  assign bus.vram_addr   = vram_addr_r;
  assign bus.vram_wdata  = vram_wdata_r;
  assign bus.wr_ready    = wr_ready_r;
  assign bus.wr_level    = level_r;
  assign bus.disp_rvalid = rd_pend_r;
  // Pass VRAM data straight through only while a read return is due; 0 otherwise.
  assign bus.disp_rdata  = rd_pend_r ? bus.vram_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_lcd_vram_arbiter.sv
// tb_lcd_vram_arbiter
//   Self-checking bench for lcd_vram_arbiter. A transaction-level model
//   (a queue of pending writes plus the expected VRAM port operation) predicts
//   every output each cycle; a vector table and directed sequences cover
//   reset, read latency, draining, full FIFO, push/pop overlap and reset
//   mid-drain, followed by randomized traffic.
module tb_lcd_vram_arbiter;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic PixelClk = 1'b0;
  logic nRST;
  always #5 PixelClk = ~PixelClk;

  lcd_vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) bus ();

  lcd_vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .PixelClk (PixelClk),
    .nRST     (nRST),
    .bus      (bus)
  );

  // VRAM macro: a read returns addr^A5A5 one cycle after the strobe, junk otherwise.
  always @(posedge PixelClk) begin
    if (bus.vram_en === 1'b1 && bus.vram_we === 1'b0)
      bus.vram_rdata <= 16'(bus.vram_addr) ^ 16'hA5A5;
    else
      bus.vram_rdata <= 16'hDEAD;
  end

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  typedef struct {
    logic              req;
    logic [ADDR_W-1:0] raddr;
    logic              wv;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              e_en;
    logic              e_we;
    int                e_lvl;
    logic              e_rdy;
    logic [ADDR_W-1:0] e_addr;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model state
  wr_t               q[$];
  logic              m_en, m_we, m_rpend;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [ADDR_W-1:0] ra, input logic wv,
                       input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
    bus.disp_req  = req;
    bus.disp_addr = ra;
    bus.wr_valid  = wv;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
  endtask

  // Advance one clock: predict from the pre-edge inputs, then compare after the edge.
  task automatic tick();
    logic acc;
    wr_t  w;
    acc = (bus.wr_valid === 1'b1) && (q.size() < DEPTH);
    if (!nRST) begin
      q.delete();
      m_en = 1'b0; m_we = 1'b0; m_rpend = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else begin
      m_rpend = m_en && !m_we;
      m_rdata = m_rpend ? (16'(m_addr) ^ 16'hA5A5) : 16'h0000;
      if (bus.disp_req) begin
        m_en = 1'b1; m_we = 1'b0; m_addr = bus.disp_addr;
      end else if (q.size() > 0) begin
        w = q.pop_front();
        m_en = 1'b1; m_we = 1'b1; m_addr = w.a; m_wdata = w.d;
      end else begin
        m_en = 1'b0; m_we = 1'b0;
      end
      if (acc) begin
        w.a = bus.wr_addr;
        w.d = bus.wr_data;
        q.push_back(w);
      end
    end
    @(posedge PixelClk);
    @(negedge PixelClk);
    chk("vram_en",     32'(bus.vram_en),     32'(m_en));
    chk("vram_we",     32'(bus.vram_we),     32'(m_we));
    chk("vram_addr",   32'(bus.vram_addr),   32'(m_addr));
    chk("vram_wdata",  32'(bus.vram_wdata),  32'(m_wdata));
    chk("disp_rvalid", 32'(bus.disp_rvalid), 32'(m_rpend));
    chk("disp_rdata",  32'(bus.disp_rdata),  32'(m_rdata));
    chk("wr_level",    32'(bus.wr_level),    32'(q.size()));
    chk("wr_ready",    32'(bus.wr_ready),    32'(q.size() < DEPTH));
  endtask

  function automatic vec_t mk(input logic req, input int ra, input logic wv, input int wa,
                              input int wd, input logic en, input logic we, input int lvl,
                              input logic rdy, input int ea);
    vec_t v;
    v.req = req; v.raddr = ADDR_W'(ra); v.wv = wv; v.wa = ADDR_W'(wa); v.wd = DATA_W'(wd);
    v.e_en = en; v.e_we = we; v.e_lvl = lvl; v.e_rdy = rdy; v.e_addr = ADDR_W'(ea);
    return v;
  endfunction

  initial begin
    nRST = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0);

    // Reset with requests active
    drive(1'b1, 17'd9, 1'b1, 17'd3, 16'h1234);
    for (int i = 0; i < 2; i++) tick();
    chk("rst_en",    32'(bus.vram_en),     32'd0);
    chk("rst_rv",    32'(bus.disp_rvalid), 32'd0);
    chk("rst_lvl",   32'(bus.wr_level),    32'd0);
    chk("rst_rdy",   32'(bus.wr_ready),    32'd1);
    nRST = 1'b1;
    drive(1'b1, 17'd7, 1'b0, '0, '0);
    tick();
    chk("first_strobe", 32'(bus.vram_en), 32'd1);
    chk("first_addr",   32'(bus.vram_addr), 32'd7);
    drive(1'b0, '0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) tick();

    // Full active line of reads
    for (int i = 0; i < 480; i++) begin
      drive(1'b1, ADDR_W'(i), 1'b0, '0, '0);
      tick();
    end
    drive(1'b0, '0, 1'b0, '0, '0);
    tick();
    chk("last_rdata", 32'(bus.disp_rdata), 32'(16'd479 ^ 16'hA5A5));
    tick();
    chk("rv_done", 32'(bus.disp_rvalid), 32'd0);

    // Vector table: idle drain, full FIFO under scanout, simultaneous push/pop
    vt.push_back(mk(0, 0,   1, 5,  'hF800, 0, 0, 1, 1, 0));
    vt.push_back(mk(0, 0,   1, 6,  'h07E0, 1, 1, 1, 1, 5));
    vt.push_back(mk(0, 0,   0, 0,  0,      1, 1, 0, 1, 6));
    vt.push_back(mk(0, 0,   0, 0,  0,      0, 0, 0, 1, 0));
    for (int i = 0; i < 6; i++)
      vt.push_back(mk(1, 100 + i, 1, 20 + i, 'h1000 + i, 1, 0,
                      (i < 3) ? i + 1 : 4, (i < 3) ? 1'b1 : 1'b0, 100 + i));
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(0, 0, 0, 0, 0, 1, 1, 3 - i, 1, 20 + i));
    vt.push_back(mk(0, 0,   0, 0,  0,      0, 0, 0, 1, 0));
    vt.push_back(mk(1, 200, 1, 30, 'h3000, 1, 0, 1, 1, 200));
    vt.push_back(mk(1, 201, 1, 31, 'h3001, 1, 0, 2, 1, 201));
    vt.push_back(mk(0, 0,   1, 32, 'h3002, 1, 1, 2, 1, 30));
    vt.push_back(mk(0, 0,   0, 0,  0,      1, 1, 1, 1, 31));
    vt.push_back(mk(0, 0,   0, 0,  0,      1, 1, 0, 1, 32));
    vt.push_back(mk(0, 0,   0, 0,  0,      0, 0, 0, 1, 0));
    foreach (vt[k]) begin
      drive(vt[k].req, vt[k].raddr, vt[k].wv, vt[k].wa, vt[k].wd);
      tick();
      chk($sformatf("tbl%0d_en", k),  32'(bus.vram_en),  32'(vt[k].e_en));
      chk($sformatf("tbl%0d_we", k),  32'(bus.vram_we),  32'(vt[k].e_we));
      chk($sformatf("tbl%0d_lvl", k), 32'(bus.wr_level), 32'(vt[k].e_lvl));
      chk($sformatf("tbl%0d_rdy", k), 32'(bus.wr_ready), 32'(vt[k].e_rdy));
      if (vt[k].e_en)
        chk($sformatf("tbl%0d_addr", k), 32'(bus.vram_addr), 32'(vt[k].e_addr));
    end

    // Reset mid-drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 17'd300, 1'b1, ADDR_W'(40 + i), DATA_W'(16'h4000 + i));
      tick();
    end
    drive(1'b0, '0, 1'b0, '0, '0);
    tick();
    chk("md_lvl3", 32'(bus.wr_level), 32'd3);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    chk("md_lvl0", 32'(bus.wr_level), 32'd0);
    chk("md_en0",  32'(bus.vram_en),  32'd0);
    tick();
    chk("md_after_en", 32'(bus.vram_en), 32'd0);

    // Randomized traffic with scanout-like bursts and occasional resets
    for (int n = 0; n < 3000; n++) begin
      nRST = ($urandom_range(0, 299) != 0);
      drive(((n % 100) < 60) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0),
            ADDR_W'($urandom_range(0, 130559)),
            $urandom_range(0, 2) != 0,
            ADDR_W'($urandom_range(0, 130559)),
            DATA_W'($urandom));
      tick();
    end
    nRST = 1'b1;
    drive(1'b0, '0, 1'b0, '0, '0);
    for (int i = 0; i < 6; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
